// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray counter and its decoder-side peers.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    // Reflected binary Gray code of a zero-extended value.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] value);
        return value ^ (value >> 1);
    endfunction

    // True when the low 'width' bits of value are all ones.
    function automatic logic is_max(input logic [MAX_WIDTH-1:0] value, input int width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '1;
        mask = mask >> (MAX_WIDTH - width);
        return (value & mask) == mask;
    endfunction

    // True when the low 'width' bits of value are all zeros.
    function automatic logic is_min(input logic [MAX_WIDTH-1:0] value, input int width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '1;
        mask = mask >> (MAX_WIDTH - width);
        return (value & mask) == '0;
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder; index 0 is the MSB on both sides.
module gray_encode
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [0:WIDTH-1] bin,
    output logic [0:WIDTH-1] gray
);

    // The MSB passes straight through; every lower bit is the XOR with its
    // more-significant neighbour, so one binary step flips one Gray bit.
    assign gray[0] = bin[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_xor
            assign gray[gi] = bin[gi-1] ^ bin[gi];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code output and wrap pulse.
// Gray is encoded from the next binary value so both registers update on the
// same edge and are never skewed against each other.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Enable,
    input  logic             Up,
    input  logic             Load,
    input  logic [0:WIDTH-1] LoadValue,
    output logic [0:WIDTH-1] Binary,
    output logic [0:WIDTH-1] Graycode,
    output logic             Wrap
);

    localparam logic [0:WIDTH-1] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:WIDTH-1] bin_reg;
    logic [0:WIDTH-1] bin_next;
    logic [0:WIDTH-1] gray_reg;
    logic [0:WIDTH-1] gray_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_max;
    logic             at_min;

    // Wrap detection on the current count, zero-extended to the helper width.
    assign at_max = is_max(MAX_WIDTH'(bin_reg), WIDTH);
    assign at_min = is_min(MAX_WIDTH'(bin_reg), WIDTH);

    // Next-count selection: load beats step, step beats hold.
    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (Load) begin
            bin_next = LoadValue;
        end else if (Enable) begin
            if (Up) begin
                bin_next  = bin_reg + ONE;
                wrap_next = at_max;
            end else begin
                bin_next  = bin_reg - ONE;
                wrap_next = at_min;
            end
        end
    end

    gray_encode #(
        .WIDTH (WIDTH)
    ) u_gray_encode (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // Output registers; reset clears them immediately, regardless of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= '0;
            gray_reg <= '0;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    assign Binary   = bin_reg;
    assign Graycode = gray_reg;
    assign Wrap     = wrap_reg;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter (WIDTH = 4) with a behavioural integer model.
module tb_gray_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Enable;
    logic         Up;
    logic         Load;
    logic [0:W-1] LoadValue;
    logic [0:W-1] Binary;
    logic [0:W-1] Graycode;
    logic         Wrap;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain modulo arithmetic on an integer count.
    int model_bin  = 0;
    bit model_wrap = 1'b0;
    bit model_step = 1'b0;
    logic [0:W-1] prev_gray = '0;

    gray_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Enable    (Enable),
        .Up        (Up),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Binary    (Binary),
        .Graycode  (Graycode),
        .Wrap      (Wrap)
    );

    always #5 clk = ~clk;

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_bin  = 0;
            model_wrap = 1'b0;
            model_step = 1'b0;
        end else if (Load) begin
            model_bin  = int'(LoadValue);
            model_wrap = 1'b0;
            model_step = 1'b0;
        end else if (Enable) begin
            model_wrap = Up ? (model_bin == (1 << W) - 1) : (model_bin == 0);
            model_bin  = Up ? (model_bin + 1) % (1 << W) : (model_bin + (1 << W) - 1) % (1 << W);
            model_step = 1'b1;
        end else begin
            model_wrap = 1'b0;
            model_step = 1'b0;
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int exp_gray;
        exp_gray = model_bin ^ (model_bin >> 1);
        checks++;
        if (int'(Binary) != model_bin || int'(Graycode) != exp_gray || Wrap != model_wrap) begin
            failures++;
            $display("FAIL model t=%0t actual bin=%b gray=%b wrap=%b required bin=%0h gray=%0h wrap=%b",
                     $time, Binary, Graycode, Wrap, model_bin, exp_gray, model_wrap);
        end
        if (model_step) begin
            checks++;
            if ($countones(Graycode ^ prev_gray) != 1) begin
                failures++;
                $display("FAIL onebit t=%0t actual prev=%b now=%b required one bit change",
                         $time, prev_gray, Graycode);
            end
        end
        prev_gray = Graycode;
    end

    task automatic lit(input string name, input logic [0:W-1] bin_a, input logic [0:W-1] gray_a,
                       input logic wrap_a, input logic [0:W-1] bin_e, input logic [0:W-1] gray_e,
                       input logic wrap_e);
        checks++;
        if (bin_a !== bin_e || gray_a !== gray_e || wrap_a !== wrap_e) begin
            failures++;
            $display("FAIL %s actual bin=%b gray=%b wrap=%b required bin=%b gray=%b wrap=%b",
                     name, bin_a, gray_a, wrap_a, bin_e, gray_e, wrap_e);
        end
    endtask

    // Apply inputs, take one rising edge, return just after it.
    task automatic step(input logic en, input logic up, input logic ld, input logic [0:W-1] lv);
        Enable    = en;
        Up        = up;
        Load      = ld;
        LoadValue = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        lit("reset_async", Binary, Graycode, Wrap, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    logic [0:W-1] up_gray [6];

    initial begin
        up_gray[0] = 4'b0001; up_gray[1] = 4'b0011; up_gray[2] = 4'b0010;
        up_gray[3] = 4'b0110; up_gray[4] = 4'b0111; up_gray[5] = 4'b0101;

        rst_n = 1'b0; Enable = 1'b0; Up = 1'b0; Load = 1'b0; LoadValue = '0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset", Binary, Graycode, Wrap, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;

        // Count up 0..6.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            lit("count_up", Binary, Graycode, Wrap, 4'(i + 1), up_gray[i], 1'b0);
        end

        // Load all ones then roll over.
        step(1'b0, 1'b0, 1'b1, 4'b1111);
        lit("load_max", Binary, Graycode, Wrap, 4'b1111, 4'b1000, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0);
        lit("rollover", Binary, Graycode, Wrap, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0);
        lit("wrap_one_cycle", Binary, Graycode, Wrap, 4'b0000, 4'b0000, 1'b0);

        // Roll under from reset.
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        lit("rollunder", Binary, Graycode, Wrap, 4'b1111, 4'b1000, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0);
        lit("down_after_wrap", Binary, Graycode, Wrap, 4'b1110, 4'b1001, 1'b0);

        // Load beats a simultaneous up step.
        step(1'b0, 1'b0, 1'b1, 4'b0101);
        lit("load_0101", Binary, Graycode, Wrap, 4'b0101, 4'b0111, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b1010);
        lit("load_priority", Binary, Graycode, Wrap, 4'b1010, 4'b1111, 1'b0);

        // Reset between edges mid-count, then resume with Enable held.
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, '0);
        lit("count_to_3", Binary, Graycode, Wrap, 4'b0011, 4'b0010, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        lit("reset_mid_cycle", Binary, Graycode, Wrap, 4'b0000, 4'b0000, 1'b0);
        Enable = 1'b1; Up = 1'b1;
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, '0);
        lit("resume_after_reset", Binary, Graycode, Wrap, 4'b0001, 4'b0001, 1'b0);

        // Hold with Up toggling.
        step(1'b0, 1'b0, 1'b1, 4'b0110);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, 4'b1111);
            lit("hold", Binary, Graycode, Wrap, 4'b0110, 4'b0101, 1'b0);
        end

        // Direction change with no dead cycle.
        step(1'b1, 1'b1, 1'b0, '0);
        lit("dir_up", Binary, Graycode, Wrap, 4'b0111, 4'b0100, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0);
        lit("dir_down", Binary, Graycode, Wrap, 4'b0110, 4'b0101, 1'b0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous up/down binary counter with a registered Gray-code output.
- Sits directly upstream of the team's binary-to-Gray stage and bench, and also serves as a self-contained Gray sequence source.
- Produces glitch-free, single-bit-change Gray codes from flops, plus the matching binary value and a wrap pulse.
- Typical consumers are pointer logic and encoder emulation.

Parameters:
- WIDTH, 4, counter width in bits; legal range is 2 to 16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Enable  input  1  count-step qualifier; one step per clk while high.
- Up  input  1  direction; 1 = increment, 0 = decrement.
- Load  input  1  synchronous load strobe.
- LoadValue  input  WIDTH  binary value to load.
- Binary  output  WIDTH  registered binary count.
- Graycode  output  WIDTH  registered Gray encoding of Binary.
- Wrap  output  1  one-cycle pulse on roll-over or roll-under.
- All vectors are declared [0:WIDTH-1], and index 0 is the MSB.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: while rst_n = 0, Binary = 0, Graycode = 0 and Wrap = 0, immediately and independently of clk.
- Reset mid-count: outputs clear immediately, and counting resumes from 0 on the first rising clk edge after rst_n rises.
- Gray encoding: Graycode[0] = Binary[0]; for i = 1..WIDTH-1, Graycode[i] = Binary[i-1] XOR Binary[i].
- Graycode is computed from the next binary value and registered in the same edge as Binary, so the two are never skewed.
- Latency: the cycle after a step/load edge shows the new Binary and Graycode together (one-edge latency).
- Priority on each rising clk edge, highest first:
  - Load = 1: Binary <= LoadValue, Graycode <= enc(LoadValue), Wrap <= 0. Enable and Up are ignored.
  - Else Enable = 1 and Up = 1: Binary <= Binary + 1, modulo 2^WIDTH.
  - Else Enable = 1 and Up = 0: Binary <= Binary - 1, modulo 2^WIDTH.
  - Else: hold, with Wrap <= 0.
- Wrap <= 1 only in two cases; it is 0 in every other cycle:
  - Up step taken while Binary is all ones.
  - Down step taken while Binary is all zeros.
- Invariant: consecutive Graycode values differ in exactly one bit after every Enable step, including wrap. After a load or hold, no bit-change guarantee applies.
- Direction change: Up may toggle on any cycle and takes effect on the same edge; no dead cycle.
- Internal structure: no FSM beyond the count register; the Wrap flop and the two output registers are the only state.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

Decomposition:
- Shared package (gray_pkg) holds:
  - Constant DEFAULT_WIDTH = 4.
  - Function bin2gray(value), shared with the decoder side.
  - Function is_max/is_min helpers for the wrap detect.
- One natural sub-module: gray_encode, a WIDTH-parameterised combinational binary-to-Gray. It is instantiated on the next-state value ahead of the Graycode register.
- The counter/next-state logic lives in gray_counter itself.

Test Plan:
- Reset, then Enable = 1, Up = 1 for 6 clocks: Graycode follows 0000, 0001, 0011, 0010, 0110, 0111, 0101 and Binary follows 0..6. The bench checks a single-bit change each step and Wrap = 0 throughout.
- Load = 1 with LoadValue = 1111, then Enable = 1, Up = 1: after the load, Binary = 1111 and Graycode = 1000. The next edge gives Binary = 0000, Graycode = 0000 and a Wrap pulse of exactly one cycle.
- From reset, Enable = 1, Up = 0: Binary = 1111 and Graycode = 1000 with Wrap = 1. The next step gives Binary = 1110, Graycode = 1001 and Wrap = 0.
- Binary = 0101, then Load = 1 with LoadValue = 1010 and Enable = 1, Up = 1 in the same cycle: the load wins, giving Binary = 1010 and Graycode = 1111 with Wrap = 0.
- Count to Binary = 0011, drop rst_n between clk edges: outputs become 0000 before the next edge. Release rst_n with Enable held: first step gives Binary = 0001, Graycode = 0001.
- Binary = 0110, Enable = 0 for 5 clocks with Up toggling: Binary stays 0110, Graycode stays 0101 and Wrap stays 0.
